nrzi_stuff_tx: RTL and testbench

USB transmit-side line encoder. It takes a serial packet bit stream (SYNC/PID/data/CRC already serialised, LSB first) over a valid/ready handshake, inserts a stuffed 0 after every STUFF_LEN consecutive 1s, and NRZI-encodes the result. It appends an EOP of EOP_LEN SE0 bit-times followed by one J bit-time. It is the counterpart of the receive-side NRZI decoder and feeds the differential line driver. One bit-time equals one clk cycle.

---
 rtl/nrzi_stuff_tx.sv | 94 +++++++++
 tb/tb_nrzi_stuff_tx.sv | 136 +++++++++++++
 2 files changed

// File: rtl/nrzi_stuff_tx.sv
// nrzi_stuff_tx: USB transmit bit stuffer and NRZI encoder with EOP generation
module nrzi_stuff_tx #(
  parameter int STUFF_LEN = 6,
  parameter int EOP_LEN   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic bit_last,
  output logic bit_ready,
  output logic nrzi_out,
  output logic se0_out,
  output logic tx_active,
  output logic underrun
);
  localparam int EW = $clog2(EOP_LEN + 1);
  typedef enum logic [2:0] {IDLE, DATA, STUFF, EOP, EOP_J} state_t;
  state_t state, state_n;
  logic [2:0] ones_cnt, ones_n;
  logic [3:0] ones_inc;
  logic [EW-1:0] eop_cnt, eop_n;
  logic last_pend, last_n, nrzi_n, se0_n, act_n, und_n, accept, hit;
  assign bit_ready = (state == IDLE) || (state == DATA);
  assign accept = bit_valid && bit_ready;
  assign ones_inc = {1'b0, ones_cnt} + 4'd1;
  assign hit = bit_in && (ones_inc == 4'(STUFF_LEN));
  always_comb begin
    state_n = state;
    ones_n  = ones_cnt;
    eop_n   = '0;
    last_n  = last_pend;
    nrzi_n  = nrzi_out;
    se0_n   = 1'b0;
    act_n   = tx_active;
    und_n   = 1'b0;
    case (state)
      IDLE, DATA: begin
        if (accept) begin
          nrzi_n  = bit_in ? nrzi_out : ~nrzi_out;
          ones_n  = bit_in ? (ones_inc[3] ? 3'd7 : ones_inc[2:0]) : 3'd0;
          act_n   = 1'b1;
          last_n  = bit_last;
          state_n = hit ? STUFF : bit_last ? EOP : DATA;
        end else if (state == DATA) begin
          und_n   = 1'b1;
          state_n = EOP;
        end else begin
          nrzi_n = 1'b1;
          act_n  = 1'b0;
          ones_n = 3'd0;
        end
      end
      STUFF: begin
        nrzi_n  = ~nrzi_out;
        ones_n  = 3'd0;
        state_n = last_pend ? EOP : DATA;
      end
      EOP: begin
        se0_n   = 1'b1;
        nrzi_n  = 1'b1;
        ones_n  = 3'd0;
        eop_n   = eop_cnt + EW'(1);
        state_n = (eop_cnt == EW'(EOP_LEN - 1)) ? EOP_J : EOP;
      end
      EOP_J: begin
        nrzi_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ones_cnt  <= '0;
      eop_cnt   <= '0;
      last_pend <= 1'b0;
      nrzi_out  <= 1'b1;
      se0_out   <= 1'b0;
      tx_active <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_n;
      ones_cnt  <= ones_n;
      eop_cnt   <= eop_n;
      last_pend <= last_n;
      nrzi_out  <= nrzi_n;
      se0_out   <= se0_n;
      tx_active <= act_n;
      underrun  <= und_n;
    end
  end
endmodule

// File: tb/tb_nrzi_stuff_tx.sv
// tb_nrzi_stuff_tx: directed and random packets checked against a bit-stream model
module tb_nrzi_stuff_tx;
  localparam int STUFF_LEN = 6;
  localparam int EOP_LEN   = 2;
  logic clk, rst, bit_in, bit_valid, bit_last;
  logic bit_ready, nrzi_out, se0_out, tx_active, underrun;
  int checks = 0, errors = 0;
  typedef struct packed {logic n, s, a, u, r;} ent_t;
  ent_t exp_q[$];
  bit pkt[$];
  nrzi_stuff_tx #(.STUFF_LEN(STUFF_LEN), .EOP_LEN(EOP_LEN)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_last(bit_last),
    .bit_ready(bit_ready), .nrzi_out(nrzi_out), .se0_out(se0_out),
    .tx_active(tx_active), .underrun(underrun)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, want);
    end
  endtask
  // Line-level expectation: stuffed stream, NRZI from J, optional underrun hold, SE0s, J
  task automatic build(input int drop);
    logic lvl = 1'b1;
    int ones = 0;
    int n = drop != 0 ? drop : pkt.size();
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      lvl = pkt[i] ? lvl : ~lvl;
      exp_q.push_back('{lvl, 1'b0, 1'b1, 1'b0, 1'b1});
      ones = pkt[i] ? ones + 1 : 0;
      if (ones == STUFF_LEN) begin
        lvl = ~lvl;
        exp_q.push_back('{lvl, 1'b0, 1'b1, 1'b0, 1'b0});
        ones = 0;
      end
    end
    if (drop != 0) exp_q.push_back('{lvl, 1'b0, 1'b1, 1'b1, 1'b1});
    for (int i = 0; i < EOP_LEN; i++) exp_q.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
  endtask
  task automatic run_pkt(input int drop);
    int idx = 0;
    int n = drop != 0 ? drop : pkt.size();
    build(drop);
    for (int j = -1; j < exp_q.size(); j++) begin
      if (j >= 0) begin
        @(posedge clk); #1;
        chk($sformatf("nrzi[%0d]", j), 8'(nrzi_out), 8'(exp_q[j].n));
        chk($sformatf("se0[%0d]", j), 8'(se0_out), 8'(exp_q[j].s));
        chk($sformatf("active[%0d]", j), 8'(tx_active), 8'(exp_q[j].a));
        chk($sformatf("underrun[%0d]", j), 8'(underrun), 8'(exp_q[j].u));
        chk($sformatf("ready[%0d]", j), 8'(bit_ready),
            8'(j + 1 < exp_q.size() ? exp_q[j + 1].r : 1'b1));
      end
      if (idx < n) begin
        bit_valid = 1'b1;
        bit_in    = pkt[idx];
        bit_last  = (idx == n - 1) && (drop == 0);
        if (bit_ready) idx++;
      end else begin
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        bit_last  = 1'b0;
      end
    end
    chk("accepted", 8'(idx), 8'(n));
  endtask
  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
      chk("idle_nrzi", 8'(nrzi_out), 8'd1);
      chk("idle_se0", 8'(se0_out), 8'd0);
      chk("idle_active", 8'(tx_active), 8'd0);
      chk("idle_ready", 8'(bit_ready), 8'd1);
    end
  endtask
  initial begin
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; bit_last = 1'b0;
    #1;
    chk("rst_nrzi", 8'(nrzi_out), 8'd1);
    chk("rst_se0", 8'(se0_out), 8'd0);
    chk("rst_active", 8'(tx_active), 8'd0);
    chk("rst_underrun", 8'(underrun), 8'd0);
    #14 rst = 1'b0;
    idle(2);
    pkt = '{0, 0, 0, 0, 0, 0, 0, 1};
    run_pkt(0);
    idle(1);
    pkt = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
    run_pkt(0);
    idle(1);
    pkt = '{1, 1, 1, 1, 1, 1};
    run_pkt(0);
    pkt = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    run_pkt(0);
    idle(1);
    pkt = '{1, 0, 1, 1, 0};
    run_pkt(3);
    idle(1);
    pkt = '{0, 1, 1, 1};
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1; bit_in = pkt[i]; bit_last = 1'b0;
      @(posedge clk); #1;
    end
    chk("pre_rst_nrzi", 8'(nrzi_out), 8'd0);
    chk("pre_rst_active", 8'(tx_active), 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_nrzi", 8'(nrzi_out), 8'd1);
    chk("async_rst_active", 8'(tx_active), 8'd0);
    chk("async_rst_se0", 8'(se0_out), 8'd0);
    bit_valid = 1'b0; bit_in = 1'b0;
    #1 rst = 1'b0;
    idle(1);
    pkt = '{1, 1, 1, 1, 0, 1};
    run_pkt(0);
    idle(1);
    for (int p = 0; p < 30; p++) begin
      int len = $urandom_range(1, 40);
      int drop = 0;
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back($urandom_range(0, 3) != 0);
      if (len > 1 && $urandom_range(0, 3) == 0) drop = $urandom_range(1, len - 1);
      run_pkt(drop);
      idle($urandom_range(0, 2));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
